// File: rtl/prs_frame_ctrl.sv
// prs_frame_ctrl: sequences the PRS symbol generator into sof/eof-framed valid/ready streams.
// Optional macro PRS_RESEED_EN adds a RESEED state that restarts the generator before every frame.
module prs_frame_ctrl #(
    parameter int FRAME_LEN = 1024,
    parameter int GAP_LEN   = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_frames,
    input  logic             i_stop,
    output logic             o_prs_req,
    output logic             o_prs_rst_n,
    input  logic             i_prs_vld,
    input  logic             i_prs_sym,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic             o_sym,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frame_cnt
);

    typedef enum logic [2:0] {IDLE, RESEED, RUN, DRAIN, GAP} state_t;

`ifdef PRS_RESEED_EN
    localparam state_t RESTART = RESEED;
`else
    localparam state_t RESTART = RUN;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] issued, wr_idx, gap_cnt, frames_lat;
    logic             stop_flag, inflight, all_done, push, pop;
    logic [2:0]       fifo_mem [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       fifo_cnt;

    // The whole run ends on a stop request or once the requested frame count has been delivered.
    assign all_done = stop_flag || (frames_lat != '0 && o_frame_cnt == frames_lat);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RESTART;
            RESEED:  state_nxt = RUN;
            RUN:     if (o_prs_req && issued == CNT_W'(FRAME_LEN - 1)) state_nxt = DRAIN;
            DRAIN: begin
                if (fifo_cnt == 3'd0 && !inflight) begin
                    if (GAP_LEN != 0) state_nxt = GAP;
                    else              state_nxt = all_done ? IDLE : RESTART;
                end
            end
            GAP:     if (gap_cnt == CNT_W'(GAP_LEN - 1)) state_nxt = all_done ? IDLE : RESTART;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            issued      <= '0;
            wr_idx      <= '0;
            gap_cnt     <= '0;
            frames_lat  <= '0;
            o_frame_cnt <= '0;
            stop_flag   <= 1'b0;
            inflight    <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= o_prs_req;
            issued   <= (state == RUN) ? issued + CNT_W'(o_prs_req) : '0;
            gap_cnt  <= (state == GAP) ? gap_cnt + CNT_W'(1) : '0;
            if (push)
                wr_idx <= (wr_idx == CNT_W'(FRAME_LEN - 1)) ? '0 : wr_idx + CNT_W'(1);
            if (state == IDLE && i_start) begin
                frames_lat  <= i_frames;
                o_frame_cnt <= '0;
                stop_flag   <= 1'b0;
            end else begin
                if (pop && fifo_mem[rd_ptr][0])
                    o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                // Stop stays pending until the run actually returns to IDLE.
                if (state_nxt == IDLE)
                    stop_flag <= 1'b0;
                else if (i_stop && state != IDLE)
                    stop_flag <= 1'b1;
            end
        end
    end

    // Credit FIFO entries are {sym, sof, eof}; tags come from the write position within the frame.
    assign push = i_prs_vld;
    assign pop  = o_vld && i_rdy;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {i_prs_sym, wr_idx == '0, wr_idx == CNT_W'(FRAME_LEN - 1)};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
        end
    end

    always @(posedge clk) begin
        if (reset_n)
            assert (!(push && fifo_cnt == 3'd4));
    end

    assign o_prs_req = (state == RUN) && (issued < CNT_W'(FRAME_LEN)) &&
                       ((fifo_cnt + 3'(inflight)) < 3'd4);

`ifdef PRS_RESEED_EN
    assign o_prs_rst_n = reset_n && (state != RESEED);
`else
    assign o_prs_rst_n = reset_n;
`endif

    assign o_vld  = (fifo_cnt != 3'd0);
    assign o_sym  = o_vld & fifo_mem[rd_ptr][2];
    assign o_sof  = o_vld & fifo_mem[rd_ptr][1];
    assign o_eof  = o_vld & fifo_mem[rd_ptr][0];
    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_prs_frame_ctrl.sv
// tb_prs_frame_ctrl: randomized bench for prs_frame_ctrl driving a behavioural PRS generator.
// Expected streams come from a frame-level model; PRS_RESEED_EN selects the matching expectations.
`timescale 1ns/1ps
module tb_prs_frame_ctrl;

    localparam int FRAME_LEN = 16;
    localparam int GAP_LEN   = 8;
    localparam int CNT_W     = 8;
`ifdef PRS_RESEED_EN
    localparam int START_LAT = 3;
    localparam bit RESEED    = 1'b1;
`else
    localparam int START_LAT = 2;
    localparam bit RESEED    = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_stop = 1'b0;
    logic             i_rdy = 1'b0;
    logic [CNT_W-1:0] i_frames = '0;
    logic             o_prs_req, o_prs_rst_n, o_vld, o_sym, o_sof, o_eof, o_busy;
    logic [CNT_W-1:0] o_frame_cnt;
    logic             prs_vld = 1'b0;
    logic             prs_sym = 1'b0;
    logic [15:0]      gen_lfsr = 16'h1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [2:0]  got_q[$];
    logic [2:0]  exp_q[$];
    longint      cyc_q[$];
    longint      cyc = 0;
    int          occ = 0;
    int          max_occ = 0;
    int          stall_err = 0;
    bit          stalled = 1'b0;
    logic [2:0]  held = 3'b0;
    logic [15:0] ref_lfsr = 16'h1;

    prs_frame_ctrl #(
        .FRAME_LEN(FRAME_LEN),
        .GAP_LEN  (GAP_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (i_start),
        .i_frames   (i_frames),
        .i_stop     (i_stop),
        .o_prs_req  (o_prs_req),
        .o_prs_rst_n(o_prs_rst_n),
        .i_prs_vld  (prs_vld),
        .i_prs_sym  (prs_sym),
        .o_vld      (o_vld),
        .i_rdy      (i_rdy),
        .o_sym      (o_sym),
        .o_sof      (o_sof),
        .o_eof      (o_eof),
        .o_busy     (o_busy),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Generator: seed 16'h1, symbol = ~msb, delivered one cycle after each request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!o_prs_rst_n) begin
            gen_lfsr <= 16'h1;
            prs_vld  <= 1'b0;
            prs_sym  <= 1'b0;
        end else begin
            prs_vld <= o_prs_req;
            if (o_prs_req) begin
                prs_sym  <= ~gen_lfsr[15];
                gen_lfsr <= lfsr_step(gen_lfsr);
            end
        end
    end

    // Records handshaken symbols, their cycle, stall stability and FIFO occupancy.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
            occ     = 0;
        end else begin
            if (stalled && (o_vld !== 1'b1 || {o_sym, o_sof, o_eof} !== held))
                stall_err++;
            stalled = o_vld && !i_rdy;
            held    = {o_sym, o_sof, o_eof};
            occ     = occ + int'(prs_vld) - int'(o_vld && i_rdy);
            if (occ > max_occ) max_occ = occ;
            if (o_vld && i_rdy) begin
                got_q.push_back(held);
                cyc_q.push_back(cyc);
            end
        end
    end

    // Reference: each frame is FRAME_LEN consecutive generator symbols, tagged sof/eof by position.
    task automatic build_expected(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            if (RESEED) ref_lfsr = 16'h1;
            for (int i = 0; i < FRAME_LEN; i++) begin
                exp_q.push_back({~ref_lfsr[15], i == 0, i == FRAME_LEN - 1});
                ref_lfsr = lfsr_step(ref_lfsr);
            end
        end
    endtask

    function automatic int stream_diff();
        int bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        if (got_q.size() > exp_q.size()) bad += got_q.size() - exp_q.size();
        return bad;
    endfunction

    task automatic clear_log();
        ref_lfsr = 16'h1;
        got_q.delete();
        exp_q.delete();
        cyc_q.delete();
        max_occ   = 0;
        stall_err = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n  = 1'b0;
        i_start  = 1'b0;
        i_stop   = 1'b0;
        i_rdy    = 1'b0;
        i_frames = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] frames);
        i_frames = frames;
        i_start  = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge clk); #1;
            if (!o_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        i_rdy   = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({o_prs_req, o_vld, o_sym, o_sof, o_eof, o_busy} !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %b, expected 000000",
                     {o_prs_req, o_vld, o_sym, o_sof, o_eof, o_busy});
        end
        n_cmp++;
        if (o_frame_cnt !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_frame_cnt: got %0d, expected 0", o_frame_cnt);
        end
        n_cmp++;
        if (o_prs_rst_n !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_prs_rst_low: got %b, expected 0", o_prs_rst_n);
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (o_prs_rst_n !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_prs_rst_high: got %b, expected 1", o_prs_rst_n);
        end
    endtask

    task automatic test_single_frame();
        int lat;
        int bad;
        bit to;
        do_reset();
        i_rdy = 1'b1;
        build_expected(1);
        pulse_start(1);
        lat = -1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (o_vld === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        if (lat !== START_LAT) begin
            n_err++;
            $display("[TB] FAIL start_latency: got %0d edges, expected %0d", lat, START_LAT);
        end
        wait_idle(200, to);
        n_cmp++;
        if (to !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_busy_fall: busy still %b, expected 0", o_busy);
        end
        bad = stream_diff();
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("[TB] FAIL single_stream: %0d bad of %0d received, expected 0 bad of %0d",
                     bad, got_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (i >= got_q.size() || got_q[i][2] !== 1'b1) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("[TB] FAIL single_first8_ones: %0d zero symbols, expected 0", bad);
        end
        n_cmp++;
        if (got_q.size() != FRAME_LEN || cyc_q[FRAME_LEN-1] - cyc_q[0] !== longint'(FRAME_LEN - 1)) begin
            n_err++;
            $display("[TB] FAIL single_throughput: %0d symbols not back to back, expected %0d consecutive",
                     got_q.size(), FRAME_LEN);
        end
        n_cmp++;
        if (o_frame_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("[TB] FAIL single_frame_cnt: got %0d, expected 1", o_frame_cnt);
        end
    endtask

    task automatic test_multi_frame();
        int  bad;
        bit  to;
        longint idle;
        do_reset();
        i_rdy = 1'b1;
        build_expected(3);
        pulse_start(3);
        wait_idle(500, to);
        n_cmp++;
        if (to !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL multi_timeout: busy still %b, expected 0", o_busy);
        end
        bad = stream_diff();
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("[TB] FAIL multi_stream: %0d bad of %0d received, expected 0 bad of %0d",
                     bad, got_q.size(), exp_q.size());
        end
        for (int f = 1; f < 3; f++) begin
            idle = (got_q.size() >= 3 * FRAME_LEN) ?
                   cyc_q[f*FRAME_LEN] - cyc_q[f*FRAME_LEN-1] - 1 : -1;
            n_cmp++;
            if (idle < GAP_LEN) begin
                n_err++;
                $display("[TB] FAIL multi_gap%0d: got %0d idle cycles, expected >= %0d", f, idle, GAP_LEN);
            end
        end
        n_cmp++;
        if (o_frame_cnt !== CNT_W'(3)) begin
            n_err++;
            $display("[TB] FAIL multi_frame_cnt: got %0d, expected 3", o_frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bit to;
        do_reset();
        build_expected(4);
        pulse_start(4);
        to = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            i_rdy = ($urandom_range(0, 99) < 30);
            @(posedge clk); #1;
            if (!o_busy) begin
                to = 1'b0;
                break;
            end
        end
        i_rdy = 1'b1;
        n_cmp++;
        if (to !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bp_timeout: busy still %b, expected 0", o_busy);
        end
        bad = stream_diff();
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("[TB] FAIL bp_stream: %0d bad of %0d received, expected 0 bad of %0d",
                     bad, got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (stall_err !== 0) begin
            n_err++;
            $display("[TB] FAIL bp_stall_stable: %0d unstable stall cycles, expected 0", stall_err);
        end
        n_cmp++;
        if (max_occ > 4) begin
            n_err++;
            $display("[TB] FAIL bp_fifo_occupancy: got %0d, expected <= 4", max_occ);
        end
        n_cmp++;
        if (o_frame_cnt !== CNT_W'(4)) begin
            n_err++;
            $display("[TB] FAIL bp_frame_cnt: got %0d, expected 4", o_frame_cnt);
        end
    endtask

    task automatic test_stop();
        int bad;
        bit to;
        bit stopped;
        do_reset();
        i_rdy  = 1'b1;
        i_stop = 1'b1;
        @(posedge clk); #1;
        i_stop = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL stop_idle_busy: got %b, expected 0", o_busy);
        end
        build_expected(2);
        pulse_start(0);
        to      = 1'b1;
        stopped = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            i_stop = 1'b0;
            if (!o_busy) begin
                to = 1'b0;
                break;
            end
            if (!stopped && got_q.size() >= FRAME_LEN + 5) begin
                i_stop  = 1'b1;
                stopped = 1'b1;
            end
        end
        i_stop = 1'b0;
        n_cmp++;
        if (to !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL stop_timeout: busy still %b, expected 0", o_busy);
        end
        bad = stream_diff();
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("[TB] FAIL stop_stream: %0d bad of %0d received, expected 0 bad of %0d",
                     bad, got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (o_frame_cnt !== CNT_W'(2)) begin
            n_err++;
            $display("[TB] FAIL stop_frame_cnt: got %0d, expected 2", o_frame_cnt);
        end
    endtask

    task automatic test_stop_at_eof();
        int bad;
        bit to;
        bit poked;
        do_reset();
        i_rdy = 1'b1;
        build_expected(2);
        pulse_start(2);
        to    = 1'b1;
        poked = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            i_stop  = 1'b0;
            i_start = 1'b0;
            if (!o_busy) begin
                to = 1'b0;
                break;
            end
            if (!poked && got_q.size() >= 4) begin
                i_frames = CNT_W'(5);
                i_start  = 1'b1;
                poked    = 1'b1;
            end
            if (o_vld && o_eof && got_q.size() >= 2 * FRAME_LEN - 1)
                i_stop = 1'b1;
        end
        i_stop  = 1'b0;
        i_start = 1'b0;
        n_cmp++;
        if (to !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL eofstop_timeout: busy still %b, expected 0", o_busy);
        end
        bad = stream_diff();
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("[TB] FAIL eofstop_stream: %0d bad of %0d received, expected 0 bad of %0d",
                     bad, got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (o_frame_cnt !== CNT_W'(2)) begin
            n_err++;
            $display("[TB] FAIL eofstop_frame_cnt: got %0d, expected 2", o_frame_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        bit to;
        do_reset();
        i_rdy = 1'b1;
        pulse_start(0);
        to = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (got_q.size() >= 5) begin
                to = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (to !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midrst_no_symbols: got %0d symbols, expected >= 5", got_q.size());
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({o_vld, o_busy} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL midrst_abort: vld/busy got %b, expected 00", {o_vld, o_busy});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({o_vld, o_frame_cnt} !== {1'b0, CNT_W'(0)}) begin
            n_err++;
            $display("[TB] FAIL midrst_empty: vld %b cnt %0d, expected vld 0 cnt 0", o_vld, o_frame_cnt);
        end
        clear_log();
        build_expected(1);
        pulse_start(1);
        wait_idle(200, to);
        bad = stream_diff();
        n_cmp++;
        if (to !== 1'b0 || bad !== 0) begin
            n_err++;
            $display("[TB] FAIL midrst_fresh_frame: timeout %b, %0d bad of %0d, expected no timeout and 0 bad of %0d",
                     to, bad, got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (o_frame_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("[TB] FAIL midrst_frame_cnt: got %0d, expected 1", o_frame_cnt);
        end
    endtask

    task automatic test_frame_cnt_wrap();
        int bad;
        bit to;
        bit stopped;
        do_reset();
        i_rdy = 1'b1;
        build_expected(257);
        pulse_start(0);
        to      = 1'b1;
        stopped = 1'b0;
        for (int k = 0; k < 12000; k++) begin
            @(posedge clk); #1;
            i_stop = 1'b0;
            if (!o_busy) begin
                to = 1'b0;
                break;
            end
            if (!stopped && got_q.size() >= 256 * FRAME_LEN + 3) begin
                i_stop  = 1'b1;
                stopped = 1'b1;
            end
        end
        i_stop = 1'b0;
        n_cmp++;
        if (to !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL wrap_timeout: busy still %b, expected 0", o_busy);
        end
        bad = stream_diff();
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("[TB] FAIL wrap_stream: %0d bad of %0d received, expected 0 bad of %0d",
                     bad, got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (o_frame_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("[TB] FAIL wrap_frame_cnt: got %0d, expected 1", o_frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_multi_frame();
        test_backpressure();
        test_stop();
        test_stop_at_eof();
        test_reset_mid_run();
        test_frame_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
